uart_rx: RTL

- UART receiver; the receive end of the codebase's 8N1 serial link (the uart_tx transmitter format).
- Oversamples RX_SERIAL with the same clocks-per-bit parameter CLK.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1.
- Frames the byte, presents it on RX_PARALLEL with a one-cycle RX_VALID strobe, and flags framing errors; sits between the pin and the core's byte consumer.

---
 rtl/uart_rx_if.sv | 32 +++
 rtl/uart_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus byte/strobe outputs of the UART receiver.
// Latency: n/a (wires only).
// Backpressure: none; the byte consumer must take each RX_VALID strobe.
// Ports: RX_SERIAL (line in), RX_PARALLEL[7:0], RX_VALID, FRAMING_ERROR,
//        BUSY, and PARITY_ERROR when UART_RX_PARITY_EN is defined.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_if;
  logic       RX_SERIAL;
  logic [7:0] RX_PARALLEL;
  logic       RX_VALID;
  logic       FRAMING_ERROR;
  logic       BUSY;
`ifdef UART_RX_PARITY_EN
  logic       PARITY_ERROR;
`endif

  modport master (
    input  RX_SERIAL,
`ifdef UART_RX_PARITY_EN
    output PARITY_ERROR,
`endif
    output RX_PARALLEL, RX_VALID, FRAMING_ERROR, BUSY
  );

  modport slave (
    output RX_SERIAL,
`ifdef UART_RX_PARITY_EN
    input  PARITY_ERROR,
`endif
    input  RX_PARALLEL, RX_VALID, FRAMING_ERROR, BUSY
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 with UART_RX_PARITY_EN defined), CLK clocks per bit.
// Latency: strobe the cycle after edge 3+H+9*CLK from the first sync capture of the start bit (10*CLK with parity).
// Backpressure: none; RX_PARALLEL is held until the next good byte, strobes are one cycle.
// Ports: CLOCK, RESET_N (async active-low), rx (uart_rx_if.master):
//   RX_SERIAL in; RX_PARALLEL, RX_VALID, FRAMING_ERROR, BUSY out;
//   PARITY_ERROR out only when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int unsigned CLK = 87
) (
  input  logic      CLOCK,
  input  logic      RESET_N,
  uart_rx_if.master rx
);

  // Start bit is re-checked at its centre; data/stop bits are sampled a full
  // bit period after that, which lands them at their centres too.
  localparam logic [15:0] HALF   = 16'((CLK - 1) / 2);
  localparam logic [15:0] CLK_M1 = 16'(CLK - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP_BIT,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic        sync1;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic [7:0]  rx_parallel;
  logic        rx_valid;
  logic        framing_error;
`ifdef UART_RX_PARITY_EN
  logic        par_bit;
  logic        parity_error;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      sync1         <= 1'b1;
      rx_s          <= 1'b1;
      cnt           <= 16'd0;
      idx           <= 3'd0;
      shift         <= 8'h00;
      rx_parallel   <= 8'h00;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      sync1         <= rx.RX_SERIAL;
      rx_s          <= sync1;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= 16'd0;
          idx <= 3'd0;
          if (!rx_s) state <= START_BIT;
        end
        START_BIT: begin
          if (cnt == HALF) begin
            cnt <= 16'd0;
            // A line back high at mid-start was a glitch: drop it silently.
            state <= rx_s ? IDLE : DATA_BITS;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA_BITS: begin
          if (cnt == CLK_M1) begin
            cnt        <= 16'd0;
            shift[idx] <= rx_s;
            if (idx == 3'd7) begin
              idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP_BIT;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CLK_M1) begin
            cnt     <= 16'd0;
            par_bit <= rx_s;
            state   <= STOP_BIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        STOP_BIT: begin
          if (cnt == CLK_M1) begin
            cnt <= 16'd0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (par_bit != ^shift) begin
                parity_error <= 1'b1;
              end else begin
                rx_parallel <= shift;
                rx_valid    <= 1'b1;
              end
`else
              rx_parallel <= shift;
              rx_valid    <= 1'b1;
`endif
              // Leaving mid-stop-bit lets a directly following start edge be caught.
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_IDLE: begin
          // A held-low (break) line must not be mistaken for a new start bit.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.RX_PARALLEL   = rx_parallel;
  assign rx.RX_VALID      = rx_valid;
  assign rx.FRAMING_ERROR = framing_error;
  assign rx.BUSY          = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx.PARITY_ERROR  = parity_error;
`endif

endmodule
